// File: rtl/sliced_seq_adder.sv
//==============================================================================
// Module      : sliced_seq_adder
// Description : Multi-cycle WIDTH-bit adder that adds SLICE bits per clock,
//               with valid/ready handshakes on the operand and result ports.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sliced_seq_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;
    logic             r_cy;

    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE:0]   w_slice_sum;

    // One ripple-carry slice per cycle; the registered carry chains slices.
    assign w_a_slice   = r_a[r_idx*SLICE +: SLICE];
    assign w_b_slice   = r_b[r_idx*SLICE +: SLICE];
    assign w_slice_sum = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{SLICE{1'b0}}, r_cy};

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_cy    <= 1'b0;
            sum     <= '0;
            carry   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_cy    <= cin;
                        r_idx   <= '0;
                        sum     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum[r_idx*SLICE +: SLICE] <= w_slice_sum[SLICE-1:0];
                    r_cy <= w_slice_sum[SLICE];
                    if (r_idx == c_last_idx) begin
                        carry   <= w_slice_sum[SLICE];
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
